fp_mc_ctrl: RTL and testbench
=============================

# fp_mc_ctrl

Controller for the iterative FP divide/square-root unit in the RV32IF pipeline. It accepts an FDIV/FSQRT leaving Execute and pulses the unit's start. It then scoreboards the pending destination register, stalling Decode on hazards. When the result is ready it arbitrates the FP register-file write port against the normal Memory→WriteBack flow, forcing a whole-pipeline stall if the multi-cycle result is starved.

## Interface
- STARVE_LIM, 4: consecutive lost write-port cycles in PEND before a forced pipeline stall (≥1).
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- StartE  in  1  multi-cycle FP op (FDIV/FSQRT) is in Execute this cycle.
- RdE  in  5  its FP destination register.
- DoneMC  in  1  one-cycle pulse from the iterative unit; its result output stays valid until the next start.
- Rs1D, Rs2D, Rs3D  in  5 each  FP source registers of the Decode instruction.
- FpUseD  in  1  Decode instruction reads FP registers.
- FpWriteD  in  1  Decode instruction writes an FP register (RdD).
- RdD  in  5  Decode destination register.
- McOpD  in  1  Decode instruction is itself FDIV/FSQRT.
- FpRegWriteW  in  1  pipeline WriteBack writes the FP register file this cycle.
- StartMC  out  1  one-cycle start pulse to the iterative unit.
- BusyMC  out  1  controller not IDLE.
- StallD  out  1  hold Fetch and Decode registers.
- FlushE  out  1  insert a bubble into Execute (equals StallD).
- StallAll  out  1  freeze F/D/E/M/W registers and gate the pipeline FP write enable.
- WbSelMC  out  1  FP write port takes the multi-cycle result this cycle.
- WbRdMC  out  5  write address for WbSelMC (the pending rd register).

## Operation
- States: IDLE, ISSUE, BUSY, PEND. Registers: state, pend_rd[4:0], starve_cnt.
- IDLE: StartE=1 → latch pend_rd←RdE, go ISSUE. Otherwise stay.
- ISSUE: StartMC=1 for exactly this cycle → BUSY. DoneMC is ignored in ISSUE.
- BUSY: on DoneMC=1 → PEND, starve_cnt←0.
- PEND with FpRegWriteW=0: WbSelMC=1, go IDLE.
- PEND with FpRegWriteW=1 and starve_cnt<STARVE_LIM-1: starve_cnt+1, stay.
- PEND with FpRegWriteW=1 and starve_cnt=STARVE_LIM-1: StallAll=1 and WbSelMC=1 in the same cycle, go IDLE.
- WbRdMC = pend_rd at all times. WbSelMC is only asserted in PEND.
- Hazard tracking is active when state≠IDLE (compare against pend_rd), or when state=IDLE and StartE=1 (compare against RdE).
- StallD=1 when hazard tracking is active and any of these holds:
  - McOpD=1.
  - FpUseD=1 and (Rs1D or Rs2D or Rs3D) equals the tracked rd.
  - FpWriteD=1 and RdD equals the tracked rd.
- FlushE = StallD.
- StallD is conservative: it still asserts in the PEND cycle that writes back. No forwarding of the multi-cycle result.
- StartE while state≠IDLE is illegal, because McOpD stalling prevents it. The controller ignores it; the bench asserts it never occurs.
- DoneMC in IDLE or PEND is ignored.
- BusyMC = (state≠IDLE).

## Timing
- Reset values: state=IDLE, pend_rd=0, starve_cnt=0; all outputs 0.
- reset asserted mid-operation aborts the pending write immediately. No WbSelMC follows; the unit is reset separately.
- StartE high in cycle N → StartMC in N+1 → BUSY from N+2.
- DoneMC in cycle K → PEND in K+1 → WbSelMC earliest in K+1.
- Worst case: WbSelMC with StallAll in K+STARVE_LIM.
- StallD/FlushE/StallAll/WbSelMC/StartMC are combinational from state and inputs, valid within the same cycle.
- Back-to-back ops: a second FDIV reaches Execute no earlier than the cycle after WbSelMC.

## Test plan
- Reset=0 mid-BUSY (pend_rd=7) → all outputs 0 next edge; no later WbSelMC.
- StartE, RdE=5; DoneMC after 10 cycles; FpRegWriteW=0 → StartMC one cycle at N+1; WbSelMC=1, WbRdMC=5 exactly one cycle after DoneMC; BusyMC drops.
- Decode reads Rs2D=5 while pend_rd=5 → StallD=FlushE=1 until the WbSelMC cycle inclusive. Rs2D=6 with other conditions clear → StallD=0.
- Second FDIV in Decode (McOpD=1) while BUSY → stalled; issues only after write-back.
- PEND with FpRegWriteW=1 continuously, STARVE_LIM=4 → three cycles with WbSelMC=0, fourth cycle StallAll=WbSelMC=1, then IDLE.
- PEND with FpRegWriteW=1 for 2 cycles then 0 → WbSelMC in cycle 3, StallAll never asserted.

Source files
------------

// File: rtl/fp_mc_ctrl.sv
// fp_mc_ctrl: issue, scoreboard and write-back arbitration for the iterative
// FP divide/sqrt unit.
// Ports:
//   in  clk, reset (async active-low), StartE, RdE[4:0], DoneMC,
//       Rs1D/Rs2D/Rs3D[4:0], FpUseD, FpWriteD, RdD[4:0], McOpD, FpRegWriteW
//   out StartMC, BusyMC, StallD, FlushE, StallAll, WbSelMC, WbRdMC[4:0]
module fp_mc_ctrl #(
    parameter int STARVE_LIM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StartE,
    input  logic [4:0] RdE,
    input  logic       DoneMC,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs3D,
    input  logic       FpUseD,
    input  logic       FpWriteD,
    input  logic [4:0] RdD,
    input  logic       McOpD,
    input  logic       FpRegWriteW,
    output logic       StartMC,
    output logic       BusyMC,
    output logic       StallD,
    output logic       FlushE,
    output logic       StallAll,
    output logic       WbSelMC,
    output logic [4:0] WbRdMC
);

    localparam int CW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;

    logic            track_en;
    logic [4:0]      track_rd;
    logic            src_hit;
    logic            dst_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_rd_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        starve_cnt_d = starve_cnt_q;
        StartMC      = 1'b0;
        StallAll     = 1'b0;
        WbSelMC      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (StartE) begin
                    pend_rd_d = RdE;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                StartMC = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                if (DoneMC) begin
                    starve_cnt_d = '0;
                    state_d      = PEND;
                end
            end
            PEND: begin
                if (!FpRegWriteW) begin
                    WbSelMC = 1'b1;
                    state_d = IDLE;
                end else if (starve_cnt_q == CNT_MAX) begin
                    // Starved too long: freeze the pipeline so its
                    // write-back slot is yielded to the pending result.
                    StallAll = 1'b1;
                    WbSelMC  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    starve_cnt_d = starve_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the op entering the unit is still in Execute, so its RdE is
    // already the register to protect.
    always_comb begin
        track_en = (state_q != IDLE) || StartE;
        track_rd = (state_q == IDLE) ? RdE : pend_rd_q;
        src_hit  = FpUseD &&
                   ((Rs1D == track_rd) ||
                    (Rs2D == track_rd) ||
                    (Rs3D == track_rd));
        dst_hit  = FpWriteD && (RdD == track_rd);
        StallD   = track_en && (McOpD || src_hit || dst_hit);
        FlushE   = StallD;
        BusyMC   = (state_q != IDLE);
        WbRdMC   = pend_rd_q;
    end

endmodule

// File: tb/tb_fp_mc_ctrl.sv
// tb_fp_mc_ctrl: directed-vector bench for fp_mc_ctrl (STARVE_LIM=4).
// Ports: none; drives every DUT input and checks every output per cycle.
module tb_fp_mc_ctrl;

    logic       clk;
    logic       reset;
    logic       StartE;
    logic [4:0] RdE;
    logic       DoneMC;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs3D;
    logic       FpUseD;
    logic       FpWriteD;
    logic [4:0] RdD;
    logic       McOpD;
    logic       FpRegWriteW;
    logic       StartMC;
    logic       BusyMC;
    logic       StallD;
    logic       FlushE;
    logic       StallAll;
    logic       WbSelMC;
    logic [4:0] WbRdMC;

    logic [10:0] outs;
    int          tests = 0;
    int          fails = 0;

    fp_mc_ctrl #(.STARVE_LIM(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .RdE        (RdE),
        .DoneMC     (DoneMC),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs3D       (Rs3D),
        .FpUseD     (FpUseD),
        .FpWriteD   (FpWriteD),
        .RdD        (RdD),
        .McOpD      (McOpD),
        .FpRegWriteW(FpRegWriteW),
        .StartMC    (StartMC),
        .BusyMC     (BusyMC),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .StallAll   (StallAll),
        .WbSelMC    (WbSelMC),
        .WbRdMC     (WbRdMC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {StartMC, BusyMC, StallD, FlushE, StallAll, WbSelMC, WbRdMC}
    assign outs = {StartMC, BusyMC, StallD, FlushE,
                   StallAll, WbSelMC, WbRdMC};

    function automatic logic [10:0] ev(input int s, input int b,
                                       input int st, input int sa,
                                       input int wb, input int rd);
        logic [4:0] r;
        r = rd[4:0];
        return {s[0], b[0], st[0], st[0], sa[0], wb[0], r};
    endfunction

    // A second op may never reach Execute while the controller is busy.
    always @(negedge clk) begin
        if (reset && StartE && BusyMC) begin
            fails++;
            $display("FAIL illegal_start: StartE=1 while BusyMC=1");
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        StartE      = 1'b0;
        RdE         = 5'd0;
        DoneMC      = 1'b0;
        Rs1D        = 5'd0;
        Rs2D        = 5'd0;
        Rs3D        = 5'd0;
        FpUseD      = 1'b0;
        FpWriteD    = 1'b0;
        RdD         = 5'd0;
        McOpD       = 1'b0;
        FpRegWriteW = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr();
        for (int c = 0; c < 3; c++) begin
            cyc();
            #2;
            tests++;
            if (outs !== ev(0, 0, 0, 0, 0, 0)) begin
                fails++;
                $display("FAIL reset c%0d: got %b want %b",
                         c, outs, ev(0, 0, 0, 0, 0, 0));
            end
        end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [10:0] e;
        for (int c = 0; c < 14; c++) begin
            cyc();
            clr();
            if (c == 0) begin
                StartE = 1'b1;
                RdE    = 5'd5;
                e = ev(0, 0, 0, 0, 0, 0);
            end else if (c == 1) begin
                e = ev(1, 1, 0, 0, 0, 5);
            end else if (c <= 10) begin
                e = ev(0, 1, 0, 0, 0, 5);
            end else if (c == 11) begin
                DoneMC = 1'b1;
                e = ev(0, 1, 0, 0, 0, 5);
            end else if (c == 12) begin
                e = ev(0, 1, 0, 0, 1, 5);
            end else begin
                e = ev(0, 0, 0, 0, 0, 5);
            end
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL single c%0d: got %b want %b", c, outs, e);
            end
        end
    endtask

    task automatic test_hazard();
        logic [10:0] e;
        for (int c = 0; c < 9; c++) begin
            cyc();
            clr();
            FpUseD = 1'b1;
            Rs2D   = 5'd5;
            case (c)
                0: begin
                    StartE = 1'b1;
                    RdE    = 5'd5;
                    e = ev(0, 0, 1, 0, 0, 5);
                end
                1: e = ev(1, 1, 1, 0, 0, 5);
                2: e = ev(0, 1, 1, 0, 0, 5);
                3: begin
                    Rs2D = 5'd6;
                    e = ev(0, 1, 0, 0, 0, 5);
                end
                4: begin
                    Rs2D     = 5'd6;
                    FpWriteD = 1'b1;
                    RdD      = 5'd5;
                    e = ev(0, 1, 1, 0, 0, 5);
                end
                5: begin
                    Rs2D = 5'd6;
                    Rs3D = 5'd5;
                    e = ev(0, 1, 1, 0, 0, 5);
                end
                6: begin
                    Rs2D   = 5'd6;
                    Rs1D   = 5'd5;
                    DoneMC = 1'b1;
                    e = ev(0, 1, 1, 0, 0, 5);
                end
                7: e = ev(0, 1, 1, 0, 1, 5);
                default: e = ev(0, 0, 0, 0, 0, 5);
            endcase
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL hazard c%0d: got %b want %b", c, outs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        for (int c = 0; c < 11; c++) begin
            cyc();
            clr();
            McOpD = (c <= 5);
            case (c)
                0: begin
                    StartE = 1'b1;
                    RdE    = 5'd3;
                    e = ev(0, 0, 1, 0, 0, 5);
                end
                1: e = ev(1, 1, 1, 0, 0, 3);
                2: e = ev(0, 1, 1, 0, 0, 3);
                3: begin
                    DoneMC = 1'b1;
                    e = ev(0, 1, 1, 0, 0, 3);
                end
                4: e = ev(0, 1, 1, 0, 1, 3);
                5: e = ev(0, 0, 0, 0, 0, 3);
                6: begin
                    StartE = 1'b1;
                    RdE    = 5'd9;
                    e = ev(0, 0, 0, 0, 0, 3);
                end
                7: e = ev(1, 1, 0, 0, 0, 9);
                8: begin
                    DoneMC = 1'b1;
                    e = ev(0, 1, 0, 0, 0, 9);
                end
                9: e = ev(0, 1, 0, 0, 1, 9);
                default: e = ev(0, 0, 0, 0, 0, 9);
            endcase
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL b2b c%0d: got %b want %b", c, outs, e);
            end
        end
    endtask

    task automatic test_starve();
        logic [10:0] e;
        for (int c = 0; c < 8; c++) begin
            cyc();
            clr();
            FpRegWriteW = (c >= 3);
            case (c)
                0: begin
                    StartE = 1'b1;
                    RdE    = 5'd12;
                    e = ev(0, 0, 0, 0, 0, 9);
                end
                1: e = ev(1, 1, 0, 0, 0, 12);
                2: begin
                    DoneMC = 1'b1;
                    e = ev(0, 1, 0, 0, 0, 12);
                end
                3, 4, 5: e = ev(0, 1, 0, 0, 0, 12);
                6: e = ev(0, 1, 0, 1, 1, 12);
                default: e = ev(0, 0, 0, 0, 0, 12);
            endcase
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL starve c%0d: got %b want %b", c, outs, e);
            end
        end
    endtask

    task automatic test_starve_partial();
        logic [10:0] e;
        for (int c = 0; c < 8; c++) begin
            cyc();
            clr();
            FpRegWriteW = (c == 4) || (c == 5);
            case (c)
                0: begin
                    StartE = 1'b1;
                    RdE    = 5'd20;
                    e = ev(0, 0, 0, 0, 0, 12);
                end
                1: begin
                    DoneMC = 1'b1;
                    e = ev(1, 1, 0, 0, 0, 20);
                end
                2: e = ev(0, 1, 0, 0, 0, 20);
                3: begin
                    DoneMC = 1'b1;
                    e = ev(0, 1, 0, 0, 0, 20);
                end
                4, 5: e = ev(0, 1, 0, 0, 0, 20);
                6: e = ev(0, 1, 0, 0, 1, 20);
                default: e = ev(0, 0, 0, 0, 0, 20);
            endcase
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL partial c%0d: got %b want %b", c, outs, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [10:0] e;
        for (int c = 0; c < 3; c++) begin
            cyc();
            clr();
            if (c == 0) begin
                StartE = 1'b1;
                RdE    = 5'd7;
                e = ev(0, 0, 0, 0, 0, 20);
            end else if (c == 1) begin
                e = ev(1, 1, 0, 0, 0, 7);
            end else begin
                e = ev(0, 1, 0, 0, 0, 7);
            end
            #2;
            tests++;
            if (outs !== e) begin
                fails++;
                $display("FAIL abort_pre c%0d: got %b want %b", c, outs, e);
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if (outs !== ev(0, 0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL abort_async: got %b want %b",
                     outs, ev(0, 0, 0, 0, 0, 0));
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            clr();
            if (c == 1) begin
                reset  = 1'b1;
                DoneMC = 1'b1;
            end
            #2;
            tests++;
            if (outs !== ev(0, 0, 0, 0, 0, 0)) begin
                fails++;
                $display("FAIL abort_post c%0d: got %b want %b",
                         c, outs, ev(0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clr();
        test_reset();
        test_single();
        test_hazard();
        test_back_to_back();
        test_starve();
        test_starve_partial();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
